// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: takes an instruction from MEM, waits for load data when needed,
// extends the load result, drives the register-file write port and retires one instruction per WRITE cycle.
module wb_pipe_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_alures,
  input  logic             ls_valid,
  input  logic [XLEN-1:0]  ls_data,
  output logic             rd_wen,
  output logic [4:0]       rd_idx,
  output logic [XLEN-1:0]  rd_data,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [31:0]      commit_instr,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("wb_pipe_stage: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_LD = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_q, alures_q, ld_res_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] ld_shift, ld_ext;
  logic            accept, in_write, is_load_q, writer_q;

  assign in_ready = (state != WAIT_LD);
  assign accept   = in_valid && in_ready;
  assign in_write = (state == WRITE);

  // Next-state logic; ls_valid only matters while waiting for a load.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY, WRITE: begin
        if (accept) state_nx = (in_instr[6:2] == OPC_LOAD) ? WAIT_LD : WRITE;
        else        state_nx = EMPTY;
      end
      WAIT_LD: if (ls_valid) state_nx = WRITE;
      default: state_nx = EMPTY;
    endcase
  end

  // Lane select and extension; bytes shifted in past the word are zero.
  always_comb begin
    ld_shift = ls_data >> {alures_q[OFF_W-1:0], 3'b000};
    ld_ext   = '0;
    case (instr_q[14:12])
      3'b000:  ld_ext = XLEN'($signed(ld_shift[7:0]));
      3'b001:  ld_ext = XLEN'($signed(ld_shift[15:0]));
      3'b010:  ld_ext = XLEN'($signed(ld_shift[31:0]));
      3'b011:  ld_ext = ld_shift;
      3'b100:  ld_ext = XLEN'(ld_shift[7:0]);
      3'b101:  ld_ext = XLEN'(ld_shift[15:0]);
      3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    is_load_q = (instr_q[6:2] == OPC_LOAD);
    case (instr_q[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_OP,
      OPC_LUI, OPC_OP_32, OPC_JALR, OPC_JAL: writer_q = 1'b1;
      default:                               writer_q = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      pc_q     <= '0;
      instr_q  <= '0;
      alures_q <= '0;
      ld_res_q <= '0;
      instret  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pc_q     <= in_pc;
        instr_q  <= in_instr;
        alures_q <= in_alures;
      end
      if (state == WAIT_LD && ls_valid) ld_res_q <= ld_ext;
      if (in_write) instret <= instret + CNT_W'(1);
    end
  end

  // Retirement port is quiet (all zero) outside WRITE.
  always_comb begin
    commit_valid = in_write;
    commit_pc    = in_write ? pc_q : '0;
    commit_instr = in_write ? instr_q : '0;
    rd_idx       = in_write ? instr_q[11:7] : 5'd0;
    rd_wen       = in_write && writer_q && (instr_q[11:7] != 5'd0);
    rd_data      = '0;
    if (in_write && writer_q) rd_data = is_load_q ? ld_res_q : alures_q;
  end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: inputs driven and outputs sampled on the falling edge.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [63:0] in_pc, in_alures, ls_data;
  logic [31:0] in_instr;
  logic        ls_valid;
  logic        rd_wen, rd_wen4;
  logic [4:0]  rd_idx, rd_idx4;
  logic [63:0] rd_data, rd_data4;
  logic        commit_valid, commit_valid4;
  logic [63:0] commit_pc, commit_pc4;
  logic [31:0] commit_instr, commit_instr4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;

  localparam logic [31:0] I_ADDI_X5 = 32'h02A0_0293;
  localparam logic [31:0] I_LB_X7   = 32'h0000_0383;
  localparam logic [31:0] I_SW      = 32'h0051_2423;
  localparam logic [31:0] I_BEQ     = 32'h0000_0063;
  localparam logic [31:0] I_ADD_X0  = 32'h0000_0033;

  always #5 clk = ~clk;

  wb_pipe_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_alures(in_alures),
    .ls_valid(ls_valid), .ls_data(ls_data),
    .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_data(rd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .instret(instret)
  );

  // Narrow counter instance sharing the same stimulus, for wrap-around.
  wb_pipe_stage #(.XLEN(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_instr(in_instr), .in_alures(in_alures),
    .ls_valid(ls_valid), .ls_data(ls_data),
    .rd_wen(rd_wen4), .rd_idx(rd_idx4), .rd_data(rd_data4),
    .commit_valid(commit_valid4), .commit_pc(commit_pc4), .commit_instr(commit_instr4),
    .instret(instret4)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_alures = '0;
    ls_valid = 1'b0; ls_data = '0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_instr = I_ADDI_X5; in_alures = 64'h55;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b exp=0", commit_valid); end
    checks++; if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0h exp=0", instret); end
    checks++; if (rd_data !== 64'd0 || commit_pc !== 64'd0) begin
      failures++; $display("FAIL reset_data rd_data=%0h commit_pc=%0h exp=0", rd_data, commit_pc); end
    @(negedge clk);
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%b exp=0", commit_valid); end
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_valid = 1'b1; in_pc = 64'h1000; in_instr = I_ADDI_X5; in_alures = 64'h2A;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (commit_valid !== 1'b1 || rd_wen !== 1'b1 || rd_idx !== 5'd5) begin
      failures++; $display("FAIL addi_commit cv=%b wen=%b idx=%0d exp 1/1/5", commit_valid, rd_wen, rd_idx); end
    checks++; if (rd_data !== 64'h2A) begin failures++; $display("FAIL addi_rd_data got=%0h exp=2a", rd_data); end
    checks++; if (commit_pc !== 64'h1000 || commit_instr !== I_ADDI_X5) begin
      failures++; $display("FAIL addi_commit_pc pc=%0h instr=%0h exp 1000/%0h", commit_pc, commit_instr, I_ADDI_X5); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL addi_instret_before got=%0d exp=%0d", instret, exp_instret); end
    @(negedge clk);
    exp_instret++;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL addi_instret_after got=%0d exp=%0d", instret, exp_instret); end
    checks++; if (commit_valid !== 1'b0 || rd_data !== 64'd0) begin
      failures++; $display("FAIL addi_idle cv=%b rd_data=%0h exp 0/0", commit_valid, rd_data); end
  endtask

  task automatic test_lb_wait();
    @(negedge clk);
    in_valid = 1'b1; in_pc = 64'h2000; in_instr = I_LB_X7; in_alures = 64'h1003;
    ls_valid = 1'b1; ls_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0; ls_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || commit_valid !== 1'b0) begin
      failures++; $display("FAIL lb_wait1 ready=%b cv=%b exp 0/0", in_ready, commit_valid); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lb_wait2 ready=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || commit_valid !== 1'b0) begin
      failures++; $display("FAIL lb_wait3 ready=%b cv=%b exp 0/0", in_ready, commit_valid); end
    ls_valid = 1'b1; ls_data = 64'h0000_0000_8000_0000;
    @(negedge clk);
    ls_valid = 1'b0; ls_data = '0;
    checks++; if (commit_valid !== 1'b1 || rd_wen !== 1'b1 || rd_idx !== 5'd7) begin
      failures++; $display("FAIL lb_commit cv=%b wen=%b idx=%0d exp 1/1/7", commit_valid, rd_wen, rd_idx); end
    checks++; if (rd_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      failures++; $display("FAIL lb_rd_data got=%0h exp=ffffffffffffff80", rd_data); end
    @(negedge clk);
    exp_instret++;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL lb_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [8] = '{3'b101, 3'b010, 3'b110, 3'b011, 3'b111, 3'b001, 3'b100, 3'b000};
    logic [63:0] adr [8] = '{64'h2002, 64'h4, 64'h4, 64'h0, 64'h0, 64'h7, 64'h1, 64'h5};
    logic [63:0] dat [8] = '{64'h0000_0000_ABCD_0000, 64'h8765_4321_0000_0000,
                             64'h8765_4321_0000_0000, 64'h1122_3344_5566_7788,
                             64'h1122_3344_5566_7788, 64'hFF00_0000_0000_0000,
                             64'h0000_0000_0000_F000, 64'h0000_7F00_0000_0000};
    logic [63:0] exp [8] = '{64'h0000_0000_0000_ABCD, 64'hFFFF_FFFF_8765_4321,
                             64'h0000_0000_8765_4321, 64'h1122_3344_5566_7788,
                             64'h0,                   64'h0000_0000_0000_00FF,
                             64'h0000_0000_0000_00F0, 64'h0000_0000_0000_007F};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_pc = 64'h3000 + 64'(4 * i);
      in_instr = {17'd0, f3[i], 5'd8, 7'b0000011}; in_alures = adr[i];
      @(negedge clk);
      in_valid = 1'b0; ls_valid = 1'b1; ls_data = dat[i];
      @(negedge clk);
      ls_valid = 1'b0;
      exp_instret++;
      checks++; if (commit_valid !== 1'b1 || rd_data !== exp[i]) begin
        failures++; $display("FAIL load_ext[%0d] f3=%b cv=%b rd_data=%0h exp=%0h", i, f3[i], commit_valid, rd_data, exp[i]); end
    end
    @(negedge clk);
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL load_ext_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3] = '{I_SW, I_BEQ, I_ADD_X0};
    @(negedge clk);
    in_valid = 1'b1; in_instr = seq[0]; in_alures = 64'h1234; in_pc = 64'h4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin in_instr = seq[i+1]; in_pc = 64'h4004 + 64'(4 * i); end
      else in_valid = 1'b0;
      checks++; if (commit_valid !== 1'b1 || rd_wen !== 1'b0 || commit_instr !== seq[i]) begin
        failures++; $display("FAIL b2b[%0d] cv=%b wen=%b instr=%0h exp 1/0/%0h", i, commit_valid, rd_wen, commit_instr, seq[i]); end
      if (i < 2) begin
        checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL b2b_rd_data[%0d] got=%0h exp=0", i, rd_data); end
      end
    end
    @(negedge clk);
    exp_instret += 3;
    checks++; if (commit_valid !== 1'b0 || instret !== exp_instret) begin
      failures++; $display("FAIL b2b_instret cv=%b instret=%0d exp 0/%0d", commit_valid, instret, exp_instret); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_LB_X7; in_alures = 64'h0; in_pc = 64'h5000;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL inflight_wait ready=%b exp=0", in_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; exp_instret = 64'd0;
    ls_valid = 1'b1; ls_data = 64'h0000_0000_0000_0011;
    checks++; if (in_ready !== 1'b1 || instret !== 64'd0) begin
      failures++; $display("FAIL inflight_reset ready=%b instret=%0d exp 1/0", in_ready, instret); end
    @(negedge clk);
    ls_valid = 1'b0;
    checks++; if (commit_valid !== 1'b0 || in_ready !== 1'b1 || instret !== 64'd0) begin
      failures++; $display("FAIL inflight_ignored cv=%b ready=%b instret=%0d exp 0/1/0", commit_valid, in_ready, instret); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = I_ADDI_X5; in_alures = 64'(i); in_pc = 64'h6000 + 64'(4 * i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    exp_instret += 17;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL wrap_instret64 got=%0d exp=%0d", instret, exp_instret); end
    checks++; if (instret4 !== 4'd1) begin failures++; $display("FAIL wrap_instret4 got=%0d exp=1", instret4); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lb_wait();
    test_load_ext();
    test_back_to_back();
    test_reset_inflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64 only.
REQ-002 Parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  MEM stage presents an instruction.
REQ-006 in_ready  output  1  stage accepts an instruction this cycle.
REQ-007 in_pc  input  XLEN  PC of presented instruction.
REQ-008 in_instr  input  32  presented instruction word.
REQ-009 in_alures  input  XLEN  ALU result; for loads, the effective address.
REQ-010 ls_valid  input  1  load data returned this cycle.
REQ-011 ls_data  input  XLEN  raw naturally-aligned word containing the load bytes.
REQ-012 rd_wen  output  1  register-file write enable.
REQ-013 rd_idx  output  5  destination register index (instr[11:7]).
REQ-014 rd_data  output  XLEN  write-back data.
REQ-015 commit_valid  output  1  one instruction retires this cycle.
REQ-016 commit_pc  output  XLEN  PC of the retiring instruction.
REQ-017 commit_instr  output  32  retiring instruction word.
REQ-018 instret  output  CNT_W  count of retired instructions.

Function
REQ-019 The stage SHALL implement states EMPTY, WAIT_LD, WRITE.
REQ-020 in_ready SHALL be 1 in EMPTY and WRITE, 0 in WAIT_LD.
REQ-021 Accept occurs when in_valid and in_ready are both 1; pc, instr, alures are registered on accept.
REQ-022 On accept, next state SHALL be WAIT_LD if instr[6:2] is LOAD (00000), else WRITE.
REQ-023 With no accept, WRITE SHALL go to EMPTY and EMPTY SHALL stay EMPTY.
REQ-024 In WAIT_LD, ls_valid=1 SHALL register the extended load result and go to WRITE; ls_valid=0 stays in WAIT_LD with no timeout.
REQ-025 ls_valid SHALL be ignored in EMPTY and WRITE, including in the accept cycle.
REQ-026 Latency: non-load accepted at cycle N retires at N+1; load whose ls_valid arrives at cycle M retires at M+1.
REQ-027 commit_valid SHALL be 1 exactly during WRITE, one cycle per instruction; commit_pc/commit_instr SHALL show the registered instruction.
REQ-028 Back-to-back accepts during WRITE SHALL sustain one retirement per cycle for non-loads.
REQ-029 rd_wen SHALL be 1 in WRITE only for opcodes OP, OP_32, OP_IMM, OP_IMM_32, LOAD, JAL, JALR, LUI, AUIPC with rd_idx != 0.
REQ-030 STORE, BRANCH and unrecognised opcodes SHALL retire (commit_valid=1) with rd_wen=0 and rd_data=0.
REQ-031 rd_data SHALL be the registered alures for non-load writers and the registered load result for LOAD.
REQ-032 Load lane: byte offset = alures[log2(XLEN/8)-1:0]; data = ls_data shifted right by 8*offset.
REQ-033 Load extension by funct3: 000 sign-8, 001 sign-16, 010 sign-32, 011 full 64, 100 zero-8, 101 zero-16, 110 zero-32.
REQ-034 For XLEN=32, funct3 010/110/011 SHALL return the full 32-bit word; funct3 111 SHALL return 0 for any XLEN.
REQ-035 Misaligned offsets are not checked; bytes shifted in beyond the word are zero before extension.
REQ-036 instret SHALL increment by 1 in every cycle commit_valid=1 and wrap modulo 2^CNT_W.
REQ-037 Outside WRITE, rd_wen, commit_valid SHALL be 0 and rd_data, commit_pc, commit_instr SHALL be 0.

Reset
REQ-038 rst_n=0 at a rising edge SHALL force EMPTY, instret=0 and all registered data to 0; in_ready=1 in the first cycle after reset.
REQ-039 Reset in WAIT_LD or WRITE SHALL drop the in-flight instruction without commit or instret change; a ls_valid arriving later is ignored.
REQ-040 While rst_n=0, in_valid SHALL not cause an accept.

Verification
REQ-041 ADDI x5 (alures=0x2A) accepted at cycle 10 -> cycle 11: commit_valid=1, rd_wen=1, rd_idx=5, rd_data=0x2A, instret 0->1.
REQ-042 LB x7, alures=0x1003, ls_data=0x0000_0000_8000_0000 with ls_valid 3 cycles after accept -> in_ready=0 during wait, retire next cycle with rd_data=0xFFFF_FFFF_FFFF_FF80.
REQ-043 LHU x8, alures=0x2002, ls_data=0x0000_0000_ABCD_0000 -> rd_data=0xABCD.
REQ-044 SW then BEQ then ADD x0 back-to-back -> three consecutive commit_valid cycles, rd_wen=0 for all, instret +3.
REQ-045 Load accepted, rst_n=0 while in WAIT_LD, then ls_valid=1 -> no commit, instret=0, state EMPTY.
REQ-046 CNT_W=4, 17 retirements -> instret=1 after wrap.
